// File: rtl/inputc_pkg.sv
// Shared router definitions for the input channel: flit format, VC geometry and type codes.
// Flit type lives in the top two bits of each flit.
package inputc_pkg;

    localparam int DATAW    = 31;
    localparam int VCH      = 1;
    localparam int VCHW     = 0;
    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 30;
    localparam int FIFOD_P1 = 2;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_TAIL     = 2'b01,
        FLIT_HEAD     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        LCK_IDLE = 1'b0,
        LCK_BUSY = 1'b1
    } lck_state_e;

    function automatic logic is_head(input logic [1:0] t);
        return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] t);
        return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/inputc_vc_fifo.sv
// Single virtual-channel flit buffer: circular storage, wrapping pointers and occupancy count.
// The head flit is presented combinationally and forced to zero while the buffer is empty.
module vc_fifo #(
    parameter int FIFOD = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PTRW = $clog2(FIFOD);
    localparam int CNTW = PTRW + 1;
    localparam logic [PTRW-1:0] PTR_ONE = PTRW'(1);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(FIFOD);

    logic [W-1:0]    mem_q [FIFOD];
    logic [W-1:0]    mem_d [FIFOD];
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            wr_fire;
    logic            rd_fire;

    assign full    = (cnt_q == CNT_MAX);
    assign empty   = (cnt_q == '0);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A write into a full buffer is dropped even if the head leaves on the same edge.
    always_comb begin
        wr_fire  = wr_en && !full;
        rd_fire  = rd_en && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_fire, rd_fire})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/inputc.sv
// Router input channel: one flit buffer per VC, per-VC packet lock and credit return.
// Define INPUTC_OVF_CHECK_EN to make oerr a sticky overflow flag; otherwise oerr is tied low.
module inputc
    import inputc_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int FIFOD    = 4
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [DATAW:0] idata,
    input  logic           ivalid,
    input  logic [VCHW:0]  ivch,
    output logic [VCH:0]   oack,
    output logic [VCH:0]   olck,
    output logic [DATAW:0] odata0,
    output logic [DATAW:0] odata1,
    output logic [VCH:0]   ovalid,
    input  logic [VCH:0]   iread,
    output logic           oerr
);

    if (FIFOD < 2 || (FIFOD & (FIFOD - 1)) != 0 || ROUTERID < 0 || PCHID < 0) begin : g_param_chk
        $error("inputc: FIFOD must be a power of two >= 2 and ids non-negative");
    end

    logic [VCH:0]   wr_en;
    logic [VCH:0]   rd_en;
    logic [VCH:0]   full;
    logic [VCH:0]   empty;
    logic [VCH:0]   wr_fire;
    logic [VCH:0]   deq;
    logic [VCH:0]   head_wr;
    logic [VCH:0]   tail_deq;
    logic [DATAW:0] head_data [VCH+1];
    logic [VCH:0]   oack_q, oack_d;

    for (genvar v = 0; v <= VCH; v++) begin : g_vc
        localparam logic [VCHW:0] VC_ID = (VCHW + 1)'(v);

        lck_state_e lck_state_q;

        // Control inputs are masked while reset is held so nothing leaks into the buffers.
        assign wr_en[v]    = ivalid && !rst_ && (ivch == VC_ID);
        assign rd_en[v]    = iread[v] && !rst_;
        assign wr_fire[v]  = wr_en[v] && !full[v];
        assign deq[v]      = rd_en[v] && !empty[v];
        assign head_wr[v]  = wr_fire[v] && is_head(idata[TYPE_MSB:TYPE_LSB]);
        assign tail_deq[v] = deq[v] && is_tail(head_data[v][TYPE_MSB:TYPE_LSB]);
        assign olck[v]     = (lck_state_q == LCK_BUSY);
        assign ovalid[v]   = !empty[v];

        vc_fifo #(
            .FIFOD (FIFOD),
            .W     (DATAW + 1)
        ) u_vc_fifo (
            .clk     (clk),
            .rst_    (rst_),
            .wr_en   (wr_en[v]),
            .wr_data (idata),
            .rd_en   (rd_en[v]),
            .rd_data (head_data[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );

        // A new head arriving on the edge the old tail leaves keeps the VC locked.
        always_ff @(posedge clk) begin
            if (rst_) begin
                lck_state_q <= LCK_IDLE;
            end else begin
                case (lck_state_q)
                    LCK_IDLE: if (head_wr[v]) lck_state_q <= LCK_BUSY;
                    LCK_BUSY: if (tail_deq[v] && !head_wr[v]) lck_state_q <= LCK_IDLE;
                    default:  lck_state_q <= LCK_IDLE;
                endcase
            end
        end
    end

    assign odata0 = head_data[0];
    assign odata1 = head_data[1];
    assign oack   = oack_q;

    always_comb begin
        oack_d = deq;
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            oack_q <= '0;
        end else begin
            oack_q <= oack_d;
        end
    end

`ifdef INPUTC_OVF_CHECK_EN
    logic oerr_q, oerr_d;

    always_comb begin
        oerr_d = oerr_q | (|(wr_en & full));
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            oerr_q <= 1'b0;
        end else begin
            oerr_q <= oerr_d;
        end
    end

    assign oerr = oerr_q;
`else
    assign oerr = 1'b0;
`endif

endmodule

// File: tb/tb_inputc.sv
// Bench for inputc: directed vector table, corner-case sequences and random traffic against a queue model.
module tb_inputc;
    import inputc_pkg::*;

    localparam int FIFOD = 4;
`ifdef INPUTC_OVF_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef logic [DATAW:0] flit_t;

    localparam logic [1:0] BD = FLIT_BODY;
    localparam logic [1:0] TL = FLIT_TAIL;
    localparam logic [1:0] HD = FLIT_HEAD;
    localparam logic [1:0] HT = FLIT_HEADTAIL;

    logic          clk = 1'b0;
    logic          rst_ = 1'b1;
    flit_t         idata = '0;
    logic          ivalid = 1'b0;
    logic [VCHW:0] ivch = '0;
    logic [VCH:0]  oack, olck, ovalid;
    logic [VCH:0]  iread = '0;
    flit_t         odata0, odata1;
    logic          oerr;

    inputc #(.ROUTERID(0), .PCHID(0), .FIFOD(FIFOD)) dut (
        .clk    (clk),
        .rst_   (rst_),
        .idata  (idata),
        .ivalid (ivalid),
        .ivch   (ivch),
        .oack   (oack),
        .olck   (olck),
        .odata0 (odata0),
        .odata1 (odata1),
        .ovalid (ovalid),
        .iread  (iread),
        .oerr   (oerr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: one queue per VC plus lock, credit and error bits.
    flit_t      q0[$];
    flit_t      q1[$];
    logic [1:0] m_lck = '0;
    logic [1:0] m_ack = '0;
    logic       m_err = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic flit_t mk(input logic [1:0] t, input int p);
        return {t, TYPE_LSB'(p)};
    endfunction

    function automatic bit starts_pkt(input flit_t f);
        return f[TYPE_MSB:TYPE_LSB] == 2'b10 || f[TYPE_MSB:TYPE_LSB] == 2'b11;
    endfunction

    function automatic bit ends_pkt(input flit_t f);
        return f[TYPE_MSB:TYPE_LSB] == 2'b01 || f[TYPE_MSB:TYPE_LSB] == 2'b11;
    endfunction

    task automatic model_step(input logic r, input logic iv, input logic ch, input flit_t d, input logic [1:0] rd);
        logic deq0, deq1, end0, end1, acc, hw;
        int   sz;
        if (r) begin
            q0.delete();
            q1.delete();
            m_lck = '0;
            m_ack = '0;
            m_err = 1'b0;
            return;
        end
        deq0 = rd[0] && q0.size() > 0;
        deq1 = rd[1] && q1.size() > 0;
        end0 = deq0 && ends_pkt(q0[0]);
        end1 = deq1 && ends_pkt(q1[0]);
        sz   = ch ? q1.size() : q0.size();
        acc  = iv && sz < FIFOD;
        hw   = acc && starts_pkt(d);
        if (hw && !ch) m_lck[0] = 1'b1; else if (end0) m_lck[0] = 1'b0;
        if (hw && ch)  m_lck[1] = 1'b1; else if (end1) m_lck[1] = 1'b0;
        if (deq0) void'(q0.pop_front());
        if (deq1) void'(q1.pop_front());
        if (acc) begin
            if (ch) q1.push_back(d); else q0.push_back(d);
        end
        m_ack = {deq1, deq0};
        if (OVF_EN && iv && !acc) m_err = 1'b1;
    endtask

    task automatic check_model();
        flit_t e0, e1;
        e0 = (q0.size() > 0) ? q0[0] : '0;
        e1 = (q1.size() > 0) ? q1[0] : '0;
        chk("ovalid", 64'(ovalid), 64'({q1.size() > 0, q0.size() > 0}));
        chk("odata0", 64'(odata0), 64'(e0));
        chk("odata1", 64'(odata1), 64'(e1));
        chk("olck",   64'(olck),   64'(m_lck));
        chk("oack",   64'(oack),   64'(m_ack));
        chk("oerr",   64'(oerr),   64'(m_err));
    endtask

    task automatic cycle(input logic r, input logic iv, input logic ch, input flit_t d, input logic [1:0] rd);
        rst_   = r;
        ivalid = iv;
        ivch   = ch;
        idata  = d;
        iread  = rd;
        @(posedge clk);
        model_step(r, iv, ch, d, rd);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       r;
        logic       iv;
        logic       ch;
        logic [1:0] ty;
        logic [1:0] rd;
        logic [1:0] e_vld;
        logic [1:0] e_lck;
        logic [1:0] e_ack;
        logic       e_ovf;
    } vec_t;

    vec_t vt[19];

    initial begin
        int ack0, ack1, reads;
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ack0, ack1, reads;
        // Reset, single HEADTAIL on VC1, empty-read, full VC0 and overflow, then drain.
        vt[0]  = '{1'b1, 1'b0, 1'b0, BD, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, BD, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, BD, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, BD, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, HT, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, BD, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, BD, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, BD, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, BD, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, HD, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, BD, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, BD, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, TL, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b0, HD, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1};
        vt[14] = '{1'b0, 1'b0, 1'b0, BD, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1};
        vt[15] = '{1'b0, 1'b0, 1'b0, BD, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1};
        vt[16] = '{1'b0, 1'b0, 1'b0, BD, 2'b01, 2'b01, 2'b01, 2'b01, 1'b1};
        vt[17] = '{1'b0, 1'b0, 1'b0, BD, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1};
        vt[18] = '{1'b0, 1'b0, 1'b0, BD, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            cycle(vt[i].r, vt[i].iv, vt[i].ch, mk(vt[i].ty, 100 + i), vt[i].rd);
            chk($sformatf("vec%0d_ovalid", i), 64'(ovalid), 64'(vt[i].e_vld));
            chk($sformatf("vec%0d_olck", i),   64'(olck),   64'(vt[i].e_lck));
            chk($sformatf("vec%0d_oack", i),   64'(oack),   64'(vt[i].e_ack));
            chk($sformatf("vec%0d_oerr", i),   64'(oerr),   64'(vt[i].e_ovf & OVF_EN));
        end

        // Simultaneous write and dequeue on a VC holding two flits.
        cycle(1'b1, 1'b0, 1'b0, '0, 2'b00);
        cycle(1'b0, 1'b1, 1'b0, mk(HD, 201), 2'b00);
        cycle(1'b0, 1'b1, 1'b0, mk(BD, 202), 2'b00);
        cycle(1'b0, 1'b1, 1'b0, mk(TL, 203), 2'b01);
        chk("simul_oack", 64'(oack), 64'(2'b01));
        chk("simul_head", 64'(odata0), 64'(mk(BD, 202)));
        reads = 0;
        for (int i = 0; i < 8 && ovalid[0]; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, 2'b01);
            if (oack[0]) reads++;
        end
        chk("simul_remaining", 64'(reads), 64'(2));
        chk("simul_unlocked", 64'(olck), 64'(2'b00));

        // Interleaved packets on both VCs with reads running on both.
        cycle(1'b1, 1'b0, 1'b0, '0, 2'b00);
        ack0 = 0;
        ack1 = 0;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] t;
            case ((i / 2) % 4)
                0:       t = HD;
                3:       t = TL;
                default: t = BD;
            endcase
            cycle(1'b0, 1'b1, 1'(i % 2), mk(t, 300 + i), 2'(i % 2 ? 2'b11 : 2'b00));
            ack0 += int'(oack[0]);
            ack1 += int'(oack[1]);
        end
        for (int i = 0; i < 8 && ovalid != 2'b00; i++) begin
            cycle(1'b0, 1'b0, 1'b0, '0, 2'b11);
            ack0 += int'(oack[0]);
            ack1 += int'(oack[1]);
        end
        cycle(1'b0, 1'b0, 1'b0, '0, 2'b00);
        chk("ilv_ack0", 64'(ack0), 64'(8));
        chk("ilv_ack1", 64'(ack1), 64'(8));
        chk("ilv_lock", 64'(olck), 64'(2'b00));

        // Reset while VC0 is mid-packet with three flits buffered.
        cycle(1'b1, 1'b0, 1'b0, '0, 2'b00);
        cycle(1'b0, 1'b1, 1'b0, mk(HD, 401), 2'b00);
        cycle(1'b0, 1'b1, 1'b0, mk(BD, 402), 2'b00);
        cycle(1'b0, 1'b1, 1'b0, mk(BD, 403), 2'b00);
        chk("pre_rst_lock", 64'(olck), 64'(2'b01));
        cycle(1'b1, 1'b1, 1'b0, mk(HD, 404), 2'b11);
        chk("rst_lock",   64'(olck),   64'(2'b00));
        chk("rst_valid",  64'(ovalid), 64'(2'b00));
        chk("rst_ack",    64'(oack),   64'(2'b00));
        chk("rst_odata0", 64'(odata0), 64'(0));
        cycle(1'b0, 1'b0, 1'b0, '0, 2'b11);
        chk("post_rst_ack", 64'(oack), 64'(2'b00));

        // Random traffic with occasional resets; reads sparse enough that VCs fill up.
        for (int i = 0; i < 1500; i++) begin
            logic       r, iv, ch;
            logic [1:0] rd, t;
            r  = ($urandom_range(199) == 0);
            iv = ($urandom_range(2) != 0);
            ch = 1'($urandom_range(1));
            t  = 2'($urandom_range(3));
            rd = {($urandom_range(2) == 0), ($urandom_range(2) == 0)};
            cycle(r, iv, ch, mk(t, int'($urandom)), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
